vga_sync_generator: RTL

Timing stage directly upstream of the VGA colour stage, running on the 25 MHz pixel clock.
- Generates 640x480@60 Hz horizontal/vertical counters, active-low hsync/vsync, display_area qualifier and current pixel coordinates.
- display_area feeds the colour stage's blanking input; x_pixel/y_pixel address the game-data lookup and the fixed ROM.
- frame_tick gives the game logic a once-per-frame update strobe at the start of vertical blanking.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 42 ++++
 rtl/vga_sync_generator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : 640x480@60 Hz timing constants and the game colour codes.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int COUNT_BIT = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Shared with the colour stage.
    typedef enum logic [1:0] {
        BLACK = 2'd0,
        GREEN = 2'd1,
        RED   = 2'd2,
        WHITE = 2'd3
    } game_colour_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : Modulo-MODULUS counter exposing its next value and wrap strobe.
// Revision : 1.0
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MODULUS = H_TOTAL,
    parameter int WIDTH   = COUNT_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(MODULUS - 1);

    always_comb begin
        wrap       = inc_en && (count == C_LAST);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (inc_en) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_generator
// Purpose  : 640x480@60 Hz sync/coordinate generator on the 25 MHz pixel clock.
//            Define VGA_SYNC_ALIGN_EN to delay hsync/vsync by one clock.
// Revision : 1.0
// ============================================================================
module vga_sync_generator #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter int COUNT_BIT = vga_timing_pkg::COUNT_BIT
) (
    input  logic                 clock_25,
    input  logic                 reset,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 display_area,
    output logic [COUNT_BIT-1:0] x_pixel,
    output logic [COUNT_BIT-1:0] y_pixel,
    output logic                 frame_tick
);

    import vga_timing_pkg::*;

    localparam int C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COUNT_BIT-1:0] C_H_VIS      = COUNT_BIT'(H_VISIBLE);
    localparam logic [COUNT_BIT-1:0] C_HS_START   = COUNT_BIT'(H_VISIBLE + H_FRONT);
    localparam logic [COUNT_BIT-1:0] C_HS_END     = COUNT_BIT'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COUNT_BIT-1:0] C_V_VIS      = COUNT_BIT'(V_VISIBLE);
    localparam logic [COUNT_BIT-1:0] C_VS_START   = COUNT_BIT'(V_VISIBLE + V_FRONT);
    localparam logic [COUNT_BIT-1:0] C_VS_END     = COUNT_BIT'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COUNT_BIT-1:0] w_h_count;
    logic [COUNT_BIT-1:0] w_h_next;
    logic [COUNT_BIT-1:0] w_v_count;
    logic [COUNT_BIT-1:0] w_v_next;
    logic                 w_h_wrap;

    logic w_display;
    logic w_hsync;
    logic w_vsync;
    logic w_tick;

    logic r_display;
    logic r_hsync;
    logic r_vsync;
    logic r_tick;

    vga_axis_counter #(
        .MODULUS (C_H_TOTAL),
        .WIDTH   (COUNT_BIT)
    ) u_h_counter (
        .clk        (clock_25),
        .reset      (reset),
        .inc_en     (1'b1),
        .count      (w_h_count),
        .count_next (w_h_next),
        .wrap       (w_h_wrap)
    );

    vga_axis_counter #(
        .MODULUS (C_V_TOTAL),
        .WIDTH   (COUNT_BIT)
    ) u_v_counter (
        .clk        (clock_25),
        .reset      (reset),
        .inc_en     (w_h_wrap),
        .count      (w_v_count),
        .count_next (w_v_next),
        .wrap       ()
    );

    // Decoding the next-state counts lets the registered flags line up
    // with the coordinates the counters will hold after this edge.
    always_comb begin
        w_display = (w_h_next < C_H_VIS) && (w_v_next < C_V_VIS);
        w_hsync   = !((w_h_next >= C_HS_START) && (w_h_next < C_HS_END));
        w_vsync   = !((w_v_next >= C_VS_START) && (w_v_next < C_VS_END));
        w_tick    = (w_h_next == '0) && (w_v_next == C_V_VIS);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_display <= 1'b0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_display <= w_display;
            r_hsync   <= w_hsync;
            r_vsync   <= w_vsync;
            r_tick    <= w_tick;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // Matches the colour stage's registered RGB so sync meets pixels at the DAC.
    logic r_hsync_d;
    logic r_vsync_d;

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_hsync_d <= 1'b1;
            r_vsync_d <= 1'b1;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign display_area = r_display;
    assign x_pixel      = w_h_count;
    assign y_pixel      = w_v_count;
    assign frame_tick   = r_tick;

endmodule
`default_nettype wire
